// File: rtl/mem_access_pkg.sv
// Shared widths, state encoding and data types for the memory access unit.
package mem_access_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {INIT, RUN} mau_state_t;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_access_unit.sv
// 64-entry command-driven storage with a post-reset clearing sweep and activity counters.
// Define MEM_ACCESS_OUTREG_EN to add a second rdata/rvalid stage (read latency 2).
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = mem_access_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_access_pkg::DATA_W,
  parameter int unsigned CNT_W  = mem_access_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic              en,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  mau_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] mem_q [Depth];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              inc_wr, inc_rd, inc_drop;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = '0;
    inc_wr    = 1'b0;
    inc_rd    = 1'b0;
    inc_drop  = 1'b0;
    unique case (state_q)
      INIT: begin
        // Sweep one entry per cycle; commands arriving now are counted and discarded.
        mem_we   = 1'b1;
        ptr_d    = ptr_q + 1'b1;
        inc_drop = en;
        if (ptr_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (en) begin
          if (wr) begin
            mem_we    = 1'b1;
            mem_waddr = addr;
            mem_wdata = wdata;
            inc_wr    = 1'b1;
          end else begin
            rdata_d  = mem_q[addr];
            rvalid_d = 1'b1;
            inc_rd   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      ptr_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Storage is deliberately not reset; the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

`ifdef MEM_ACCESS_OUTREG_EN
  logic [DATA_W-1:0] rdata2_q, rdata2_d;
  logic              rvalid2_q, rvalid2_d;

  always_comb begin
    rvalid2_d = rvalid_q;
    rdata2_d  = rvalid_q ? rdata_q : rdata2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata2_q  <= '0;
      rvalid2_q <= 1'b0;
    end else begin
      rdata2_q  <= rdata2_d;
      rvalid2_q <= rvalid2_d;
    end
  end

  assign rdata  = rdata2_q;
  assign rvalid = rvalid2_q;
`else
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

  assign ready = (state_q == RUN);

  sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc_wr),
    .cnt (wr_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc_rd),
    .cnt (rd_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc_drop),
    .cnt (drop_cnt)
  );

endmodule
